// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a valid/ready byte FIFO feeding a
// start/data/stop shifter with elaboration-time baud timing.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wr_valid_i,
    input  logic [7:0]                    wr_data_i,
    output logic                          wr_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   level_q, level_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          push, pop, empty, full, bit_end;

    assign full    = (level_q == (PW+1)'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign push    = wr_valid_i && !full;
    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign level_d = level_q + (PW+1)'(push) - (PW+1)'(pop);

    assign wr_ready_o = !full;
    assign level_o    = level_q;
    assign tx_o       = tx_q;

    always_ff @(posedge wb_clk_i) begin
        if (push && !wb_rst_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; STOP reloads straight into START so frames abut
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the line level is computed from the next state and registered
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_o = (state_q != IDLE) || !empty;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a serial receiver model pops an expected-byte
// scoreboard, while per-scenario tasks check timing and FIFO status.
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i;
    logic       wr_valid_i;
    logic [7:0] wr_data_i;
    logic       wr_ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [3:0] level_o;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] sb[$];
    int         rx_starts[$];
    bit         rx_busy = 1'b0;
    int         rx_count = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .tx_o       (tx_o),
        .busy_o     (busy_o),
        .level_o    (level_o)
    );

    initial forever #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // Serial receiver: samples mid-bit from the first low cycle, aborts on reset
    initial begin : rx
        int         cnt;
        logic [7:0] sh;
        logic       rst_s;
        logic [7:0] exp_b;
        cnt = 0;
        sh  = '0;
        forever begin
            @(posedge wb_clk_i);
            rst_s = wb_rst_i;
            #2;
            if (rst_s === 1'b1) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (tx_o === 1'b0) begin
                    rx_busy = 1'b1;
                    cnt = 0;
                    rx_starts.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt >= 24 && cnt <= 136 && ((cnt - 24) % 16) == 0) begin
                    sh = {tx_o, sh[7:1]};
                end else if (cnt == 152) begin
                    rx_busy = 1'b0;
                    rx_count++;
                    vectors++;
                    if (tx_o !== 1'b1) begin
                        miscompares++;
                        $display("FAIL rx_stop: stop bit=%b, want 1", tx_o);
                    end
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL rx_unexpected: got byte %h, want none", sh);
                    end else begin
                        exp_b = sb.pop_front();
                        if (sh !== exp_b) begin
                            miscompares++;
                            $display("FAIL rx_byte: got %h, want %h", sh, exp_b);
                        end
                    end
                end
            end
        end
    end

    // All tasks are entered and left 1 time unit after a rising edge
    task automatic push_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        acc = -1;
        wr_valid_i = 1'b1;
        wr_data_i  = b;
        while (!wr_ready_o && n < 2000) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        if (n >= 2000) begin
            wr_valid_i = 1'b0;
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: byte %h never accepted", b);
        end else begin
            @(posedge wb_clk_i); #1;
            wr_valid_i = 1'b0;
            sb.push_back(b);
            acc = cyc;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (!(busy_o === 1'b0 && !rx_busy) && n < 5000) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        ok = (n < 5000);
    endtask

    task automatic wait_until(input int t);
        int n;
        n = 0;
        while (cyc < t && n < 5000) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
    endtask

    task automatic wait_start(output int s);
        int n;
        n = 0;
        while (rx_starts.size() == 0 && n < 2000) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        s = (rx_starts.size() > 0) ? rx_starts[0] : -100000;
    endtask

    task automatic test_reset;
        wb_rst_i   = 1'b1;
        wr_valid_i = 1'b0;
        wr_data_i  = 8'h00;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        vectors++;
        if (tx_o !== 1'b1 || wr_ready_o !== 1'b1 || busy_o !== 1'b0 || level_o !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: tx=%b ready=%b busy=%b level=%0d, want 1 1 0 0",
                     tx_o, wr_ready_o, busy_o, level_o);
        end
    endtask

    task automatic test_single;
        int acc, c0;
        bit ok;
        rx_starts.delete();
        c0 = rx_count;
        push_byte(8'hA4, acc);
        vectors++;
        if (tx_o !== 1'b1 || level_o !== 4'd1) begin
            miscompares++;
            $display("FAIL single_accept: tx=%b level=%0d, want 1 1", tx_o, level_o);
        end
        @(posedge wb_clk_i); #1;
        vectors++;
        if (tx_o !== 1'b0 || level_o !== 4'd0) begin
            miscompares++;
            $display("FAIL single_start: tx=%b level=%0d, want 0 0", tx_o, level_o);
        end
        wait_idle(ok);
        vectors++;
        if (!ok || cyc - (acc + 1) != 10 * CPB) begin
            miscompares++;
            $display("FAIL single_busy: busy fell %0d cycles after start, want %0d",
                     cyc - (acc + 1), 10 * CPB);
        end
        vectors++;
        if (sb.size() != 0 || rx_count - c0 != 1) begin
            miscompares++;
            $display("FAIL single_rx: received %0d, pending %0d, want 1 0", rx_count - c0, sb.size());
        end
    endtask

    task automatic test_back_to_back;
        int acc;
        bit ok;
        rx_starts.delete();
        push_byte(8'h48, acc);
        push_byte(8'h69, acc);
        push_byte(8'h0A, acc);
        wait_idle(ok);
        vectors++;
        if (!ok || rx_starts.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_frames: %0d frames, want 3", rx_starts.size());
        end else begin
            vectors++;
            if (rx_starts[1] - rx_starts[0] != 10 * CPB || rx_starts[2] - rx_starts[1] != 10 * CPB) begin
                miscompares++;
                $display("FAIL b2b_gap: gaps %0d %0d, want %0d", rx_starts[1] - rx_starts[0],
                         rx_starts[2] - rx_starts[1], 10 * CPB);
            end
            vectors++;
            if (cyc - rx_starts[0] != 30 * CPB) begin
                miscompares++;
                $display("FAIL b2b_span: %0d cycles, want %0d", cyc - rx_starts[0], 30 * CPB);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_pending: %0d bytes left, want 0", sb.size());
        end
    endtask

    task automatic test_full;
        int  n, guard;
        logic rdy;
        bit  ok;
        rx_starts.delete();
        n = 0;
        guard = 0;
        wr_valid_i = 1'b1;
        wr_data_i  = 8'h00;
        rdy = wr_ready_o;
        while (n < 9 && guard < 50) begin
            @(posedge wb_clk_i); #1;
            guard++;
            if (rdy) begin
                sb.push_back(8'(n));
                n++;
                wr_data_i = 8'(n);
            end
            rdy = wr_ready_o;
        end
        vectors++;
        if (n != 9 || wr_ready_o !== 1'b0 || level_o !== 4'd8) begin
            miscompares++;
            $display("FAIL full_stall: accepted=%0d ready=%b level=%0d, want 9 0 8", n, wr_ready_o, level_o);
        end
        guard = 0;
        while (wr_ready_o !== 1'b1 && guard < 400) begin
            @(posedge wb_clk_i); #1;
            guard++;
        end
        wr_valid_i = 1'b0;
        vectors++;
        if (rx_starts.size() == 0 || cyc - rx_starts[0] != 10 * CPB || level_o !== 4'd7) begin
            miscompares++;
            $display("FAIL full_ready_rise: at +%0d level=%0d, want +%0d level=7",
                     (rx_starts.size() > 0) ? cyc - rx_starts[0] : -1, level_o, 10 * CPB);
        end
        wait_idle(ok);
        vectors++;
        if (!ok || sb.size() != 0) begin
            miscompares++;
            $display("FAIL full_drain: %0d bytes left, want 0", sb.size());
        end
    endtask

    task automatic test_simul;
        int acc, s;
        bit ok;
        rx_starts.delete();
        for (int i = 0; i < 4; i++) push_byte(8'h31 + 8'(i), acc);
        wait_start(s);
        wait_until(s + 10 * CPB - 1);
        vectors++;
        if (level_o !== 4'd3 || wr_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_pre: level=%0d ready=%b, want 3 1", level_o, wr_ready_o);
        end
        wr_valid_i = 1'b1;
        wr_data_i  = 8'h35;
        @(posedge wb_clk_i); #1;
        wr_valid_i = 1'b0;
        sb.push_back(8'h35);
        vectors++;
        if (level_o !== 4'd3 || tx_o !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_level: level=%0d tx=%b, want 3 0", level_o, tx_o);
        end
        wait_idle(ok);
        vectors++;
        if (!ok || sb.size() != 0) begin
            miscompares++;
            $display("FAIL simul_drain: %0d bytes left, want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid;
        int acc, s;
        bit ok, hi;
        rx_starts.delete();
        push_byte(8'h55, acc);
        push_byte(8'hAA, acc);
        push_byte(8'h0F, acc);
        wait_start(s);
        wait_until(s + 5 * CPB + 8);
        vectors++;
        if (tx_o !== 1'b1 || level_o !== 4'd2) begin
            miscompares++;
            $display("FAIL rstmid_pre: tx=%b level=%0d, want 1 2", tx_o, level_o);
        end
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        vectors++;
        if (tx_o !== 1'b1 || level_o !== 4'd0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_state: tx=%b level=%0d busy=%b, want 1 0 0", tx_o, level_o, busy_o);
        end
        sb.delete();
        rx_starts.delete();
        hi = 1'b1;
        repeat (400) begin
            @(posedge wb_clk_i); #1;
            if (tx_o !== 1'b1 || busy_o !== 1'b0) hi = 1'b0;
        end
        vectors++;
        if (!hi || rx_starts.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet: line_high=%b frames=%0d, want 1 0", hi, rx_starts.size());
        end
        push_byte(8'h3C, acc);
        wait_idle(ok);
        vectors++;
        if (!ok || sb.size() != 0 || rx_starts.size() != 1) begin
            miscompares++;
            $display("FAIL rstmid_after: pending=%0d frames=%0d, want 0 1", sb.size(), rx_starts.size());
        end
    endtask

    task automatic test_wrap;
        int acc, c0, g;
        bit ok;
        c0 = rx_count;
        for (int i = 0; i < 20; i++) begin
            push_byte(8'h10 + 8'(i), acc);
            g = $urandom_range(0, 200);
            repeat (g) begin
                @(posedge wb_clk_i); #1;
            end
        end
        wait_idle(ok);
        vectors++;
        if (!ok || sb.size() != 0 || rx_count - c0 != 20) begin
            miscompares++;
            $display("FAIL wrap_stream: received %0d pending %0d, want 20 0", rx_count - c0, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_simul();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
